// File: rtl/che_cdf_prefix_acc_pkg.sv
// Shared types and defaults for the CHE cumulative-histogram (CDF) path.
package che_cdf_prefix_acc_pkg;

    localparam int DEF_DAT_IN_WD = 16;
    localparam int DEF_LANE_NUM  = 4;
    localparam int DEF_CDF_WD    = 24;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } acc_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/che_cdf_lane_prefix.sv
// Combinational Kogge-Stone inclusive prefix sum across the lanes of one beat.
module che_cdf_lane_prefix #(
    parameter int IN_WD    = 16,
    parameter int LANE_NUM = 4
) (
    input  logic [IN_WD*LANE_NUM-1:0]                     dat_i,
    output logic [(IN_WD+$clog2(LANE_NUM))*LANE_NUM-1:0]  pfx_o
);

    localparam int LVL_NUM = $clog2(LANE_NUM);
    localparam int OUT_WD  = IN_WD + LVL_NUM;

    logic [OUT_WD-1:0] lvl [LVL_NUM+1][LANE_NUM];

    genvar gi, gl;
    generate
        for (gi = 0; gi < LANE_NUM; gi++) begin : g_in
            assign lvl[0][gi] = OUT_WD'(dat_i[gi*IN_WD +: IN_WD]);
            assign pfx_o[gi*OUT_WD +: OUT_WD] = lvl[LVL_NUM][gi];
        end
        // Level gl adds the partial sum 2^gl lanes below.
        for (gl = 0; gl < LVL_NUM; gl++) begin : g_lvl
            for (gi = 0; gi < LANE_NUM; gi++) begin : g_node
                if (gi >= (1 << gl)) begin : g_add
                    assign lvl[gl+1][gi] = lvl[gl][gi] + lvl[gl][gi-(1<<gl)];
                end else begin : g_pass
                    assign lvl[gl+1][gi] = lvl[gl][gi];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/che_cdf_prefix_acc.sv
// Streaming CDF generator: intra-beat prefix (S1) plus cross-beat base accumulation (S2),
// valid/ready on both sides.
module che_cdf_prefix_acc
    import che_cdf_prefix_acc_pkg::*;
#(
    parameter int DAT_IN_WD = DEF_DAT_IN_WD,
    parameter int LANE_NUM  = DEF_LANE_NUM,
    parameter int CDF_WD    = DEF_CDF_WD,
    parameter bit SAT_EN    = 1'b1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          vld_i,
    output logic                          rdy_o,
    input  logic                          sof_i,
    input  logic                          eof_i,
    input  logic [DAT_IN_WD*LANE_NUM-1:0] dat_i,
    output logic                          vld_o,
    input  logic                          rdy_i,
    output logic                          sof_o,
    output logic                          eof_o,
    output logic [CDF_WD*LANE_NUM-1:0]    cdf_o,
    output logic [CDF_WD-1:0]             tot_o,
    output logic                          ovf_o
);

    localparam int P_WD   = DAT_IN_WD + $clog2(LANE_NUM);
    // Wide enough that neither operand can carry out unnoticed.
    localparam int SUM_WD = max_int(P_WD, CDF_WD) + 1;
    localparam logic [CDF_WD-1:0] CDF_MAX = '1;

    acc_state_e                   state_reg, state_next;
    logic                         s1_vld_reg, s1_sof_reg, s1_eof_reg;
    logic [P_WD*LANE_NUM-1:0]     s1_pfx_reg, pfx;
    logic                         s2_vld_reg, s2_sof_reg, s2_eof_reg;
    logic [CDF_WD*LANE_NUM-1:0]   s2_cdf_reg, cdf_next;
    logic [CDF_WD-1:0]            base_reg, base_eff, cdf_last, tot_reg;
    logic                         ovf_reg;
    logic [LANE_NUM-1:0]          lane_ovf;
    logic                         drop, keep, in_xfer, s1_ld, s2_ld;

    che_cdf_lane_prefix #(
        .IN_WD    (DAT_IN_WD),
        .LANE_NUM (LANE_NUM)
    ) u_prefix (
        .dat_i (dat_i),
        .pfx_o (pfx)
    );

    // Stray beats outside a histogram are swallowed without waiting on the pipeline.
    assign drop    = (state_reg == ST_IDLE) & ~sof_i;
    assign keep    = ~drop;
    assign s2_ld   = s1_vld_reg & (~s2_vld_reg | rdy_i);
    assign rdy_o   = ~s1_vld_reg | s2_ld | drop;
    assign in_xfer = vld_i & rdy_o;
    assign s1_ld   = in_xfer & keep;

    always_comb begin
        state_next = state_reg;
        if (in_xfer) begin
            case (state_reg)
                ST_IDLE: if (sof_i && !eof_i) state_next = ST_ACC;
                ST_ACC:  if (eof_i) state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign base_eff = s1_sof_reg ? '0 : base_reg;

    genvar gi;
    generate
        for (gi = 0; gi < LANE_NUM; gi++) begin : g_lane
            logic [SUM_WD-1:0] sum;
            assign sum          = SUM_WD'(base_eff) + SUM_WD'(s1_pfx_reg[gi*P_WD +: P_WD]);
            assign lane_ovf[gi] = |sum[SUM_WD-1:CDF_WD];
            assign cdf_next[gi*CDF_WD +: CDF_WD] =
                (SAT_EN && lane_ovf[gi]) ? CDF_MAX : sum[CDF_WD-1:0];
        end
    endgenerate

    assign cdf_last = cdf_next[CDF_WD*LANE_NUM-1 -: CDF_WD];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg  <= ST_IDLE;
            s1_vld_reg <= 1'b0;
            s1_sof_reg <= 1'b0;
            s1_eof_reg <= 1'b0;
            s1_pfx_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (s1_ld) begin
                s1_vld_reg <= 1'b1;
                s1_sof_reg <= sof_i;
                s1_eof_reg <= eof_i;
                s1_pfx_reg <= pfx;
            end else if (s2_ld) begin
                s1_vld_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_vld_reg <= 1'b0;
            s2_sof_reg <= 1'b0;
            s2_eof_reg <= 1'b0;
            s2_cdf_reg <= '0;
            base_reg   <= '0;
            tot_reg    <= '0;
            ovf_reg    <= 1'b0;
        end else if (s2_ld) begin
            s2_vld_reg <= 1'b1;
            s2_sof_reg <= s1_sof_reg;
            s2_eof_reg <= s1_eof_reg;
            s2_cdf_reg <= cdf_next;
            base_reg   <= s1_eof_reg ? '0 : cdf_last;
            // A new histogram starts with a clean flag, unless its first beat overflows.
            ovf_reg    <= (ovf_reg & ~s1_sof_reg) | (|lane_ovf);
            if (s1_eof_reg) tot_reg <= cdf_last;
        end else if (rdy_i) begin
            s2_vld_reg <= 1'b0;
        end
    end

    assign vld_o = s2_vld_reg;
    assign sof_o = s2_sof_reg;
    assign eof_o = s2_eof_reg;
    assign cdf_o = s2_cdf_reg;
    assign tot_o = tot_reg;
    assign ovf_o = ovf_reg;

endmodule
